// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncing logic: FSM state type,
// default debounce length and a constant clog2 helper.
package debounce_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } deb_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 120000;

    // Bits needed to hold values 0 .. value-1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned w;
        v = value - 1;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous board input; both flops are
// kept adjacent by the ASYNC_REG attribute.
module sync_2ff #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic CLK_12MHz,
    input  logic RST_N,
    input  logic D,
    output logic Q
);

    (* ASYNC_REG = "TRUE" *) logic r_q1;
    (* ASYNC_REG = "TRUE" *) logic r_q2;

    always_ff @(posedge CLK_12MHz) begin
        if (!RST_N) begin
            r_q1 <= RESET_LEVEL;
            r_q2 <= RESET_LEVEL;
        end else begin
            r_q1 <= D;
            r_q2 <= r_q1;
        end
    end

    assign Q = r_q2;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the mechanical switch input: synchronise, qualify a level change
// for DEBOUNCE_CYCLES cycles, then emit the new level with a one-cycle edge pulse.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic CLK_12MHz,
    input  logic RST_N,
    input  logic SW_IN,
    output logic SW_OUT,
    output logic SW_FALL,
    output logic SW_RISE
);

    localparam int unsigned      CNT_W    = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_sync;
    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_out;
    logic             w_out_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             r_rise;
    logic             w_rise_nxt;

    sync_2ff #(
        .RESET_LEVEL(RESET_LEVEL)
    ) u_sync (
        .CLK_12MHz(CLK_12MHz),
        .RST_N    (RST_N),
        .D        (SW_IN),
        .Q        (w_sync)
    );

    always_ff @(posedge CLK_12MHz) begin
        if (!RST_N) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_out   <= RESET_LEVEL;
            r_fall  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_fall  <= w_fall_nxt;
            r_rise  <= w_rise_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_fall_nxt  = 1'b0;
        w_rise_nxt  = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_sync != r_out) begin
                    w_state_nxt = ST_QUALIFY;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_QUALIFY: begin
                // Any cycle of agreement abandons the attempt; a new one starts from 0
                if (w_sync == r_out) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = w_sync;
                    w_fall_nxt  = ~w_sync;
                    w_rise_nxt  = w_sync;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign SW_OUT  = r_out;
    assign SW_FALL = r_fall;
    assign SW_RISE = r_rise;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (DEBOUNCE_CYCLES=8): each driven cycle
// queues the expected outputs, which are compared one half-cycle after the edge.
module tb_switch_debouncer;

    localparam int unsigned DEB = 8;

    typedef struct packed {
        logic out;
        logic fall;
        logic rise;
    } exp_t;

    logic CLK_12MHz = 1'b0;
    logic RST_N     = 1'b0;
    logic SW_IN     = 1'b1;
    logic SW_OUT;
    logic SW_FALL;
    logic SW_RISE;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    logic hist[$];
    logic m_out   = 1'b1;
    int   cnt_max = 0;

    switch_debouncer #(
        .DEBOUNCE_CYCLES(DEB),
        .RESET_LEVEL    (1'b1)
    ) dut (
        .CLK_12MHz(CLK_12MHz),
        .RST_N    (RST_N),
        .SW_IN    (SW_IN),
        .SW_OUT   (SW_OUT),
        .SW_FALL  (SW_FALL),
        .SW_RISE  (SW_RISE)
    );

    always #5 CLK_12MHz = ~CLK_12MHz;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the output flips at edge e when the inputs sampled at edges
    // e-9 .. e-2 all differ from the current output (reset edges sample 1).
    task automatic tick(input logic sw, input logic rst);
        exp_t e;
        logic win;
        SW_IN = sw;
        RST_N = rst;
        if (!rst) begin
            e = '{out: 1'b1, fall: 1'b0, rise: 1'b0};
            m_out = 1'b1;
            hist.push_back(1'b1);
        end else begin
            win = (hist.size() >= 9);
            if (win) begin
                for (int j = 2; j <= 9; j++) begin
                    if (hist[hist.size() - j] == m_out) win = 1'b0;
                end
            end
            e.out  = win ? ~m_out : m_out;
            e.fall = win & m_out;
            e.rise = win & ~m_out;
            m_out  = e.out;
            hist.push_back(sw);
        end
        exp_q.push_back(e);
        @(posedge CLK_12MHz);
        #1;
        if (int'(dut.r_cnt) > cnt_max) cnt_max = int'(dut.r_cnt);
    endtask

    always @(negedge CLK_12MHz) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sw_out",  int'(SW_OUT),  int'(e.out));
            check("sw_fall", int'(SW_FALL), int'(e.fall));
            check("sw_rise", int'(SW_RISE), int'(e.rise));
            check("pulse_excl", int'(SW_FALL & SW_RISE), 0);
        end
    end

    initial begin
        logic hit;

        // Reset with the switch already pressed, then release reset
        repeat (3) tick(1'b0, 1'b0);
        repeat (12) tick(1'b0, 1'b1);

        // Release, clean press, release again
        repeat (12) tick(1'b1, 1'b1);
        repeat (12) tick(1'b0, 1'b1);
        repeat (12) tick(1'b1, 1'b1);

        // Bounce: toggle every 3 cycles, then settle high
        for (int k = 0; k < 40; k++) tick(((k / 3) % 2) == 0 ? 1'b0 : 1'b1, 1'b1);
        repeat (12) tick(1'b1, 1'b1);

        // Terminal-edge revert: one sample short of qualifying
        cnt_max = 0;
        repeat (DEB - 1) tick(1'b0, 1'b1);
        repeat (12) tick(1'b1, 1'b1);
        check("cnt_reaches_last", cnt_max, DEB - 1);

        // Just long enough to qualify, then back high
        repeat (DEB) tick(1'b0, 1'b1);
        repeat (4) tick(1'b1, 1'b1);
        repeat (14) tick(1'b1, 1'b1);

        // Reset in the middle of qualification
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            tick(1'b0, 1'b1);
            if (dut.r_cnt == 3'd5) hit = 1'b1;
        end
        check("reach_cnt5", int'(hit), 1);
        tick(1'b0, 1'b0);
        check("rst_cnt_clear", int'(dut.r_cnt), 0);
        tick(1'b0, 1'b0);
        repeat (12) tick(1'b0, 1'b1);
        repeat (12) tick(1'b1, 1'b1);

        // Held constant: nothing happens
        repeat (30) tick(1'b1, 1'b1);

        @(negedge CLK_12MHz);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
